// File: rtl/mbscore_alu_mc.sv
// MBScore execute-stage ALU: single-cycle logic/arith ops plus
// iterative MUL/MULHU/DIVU/REMU behind valid/ready handshakes.
module mbscore_alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_cf,
  output logic                  out_dz
);

  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int CNT_W   = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADDU  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SUBU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_NOR   = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_EQ    = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_NE    = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_LT    = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_LTU   = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(17);
  localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(18);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [W-1:0]        b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]      acc_q, acc_d;
  logic [W-1:0]        res_q, res_d;
  logic                cf_q, cf_d;
  logic                dz_q, dz_d;

  logic                accept;
  logic                in_long;
  logic [W:0]          sum_w;
  logic [W:0]          diff_w;
  logic [SHAMT_W-1:0]  shamt;
  logic [W-1:0]        short_res;
  logic                short_cf;

  logic                op_div;
  logic                op_lo;
  logic [W:0]          mul_sum;
  logic [2*W-1:0]      mul_acc;
  logic [W:0]          rem_sh;
  logic [W:0]          div_try;
  logic [2*W-1:0]      div_acc;
  logic [2*W-1:0]      step_acc;

  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = res_q;
  assign out_cf    = cf_q;
  assign out_dz    = dz_q;

  assign in_long = (in_op == OP_MUL)  || (in_op == OP_MULHU) ||
                   (in_op == OP_DIVU) || (in_op == OP_REMU);

  always_comb begin
    sum_w     = {1'b0, in_a} + {1'b0, in_b};
    diff_w    = {1'b0, in_a} - {1'b0, in_b};
    shamt     = in_b[SHAMT_W-1:0];
    short_res = '0;
    short_cf  = 1'b0;
    unique case (in_op)
      OP_ADD:  {short_cf, short_res} = sum_w;
      OP_ADDU: short_res = sum_w[W-1:0];
      OP_SUB:  {short_cf, short_res} = diff_w;
      OP_SUBU: short_res = diff_w[W-1:0];
      OP_AND:  short_res = in_a & in_b;
      OP_OR:   short_res = in_a | in_b;
      OP_XOR:  short_res = in_a ^ in_b;
      OP_NOR:  short_res = ~(in_a | in_b);
      OP_SLL:  short_res = in_a << shamt;
      OP_SRL:  short_res = in_a >> shamt;
      OP_SRA:  short_res = W'($signed(in_a) >>> shamt);
      OP_EQ:   short_res = W'(in_a == in_b);
      OP_NE:   short_res = W'(in_a != in_b);
      OP_LT:   short_res = W'($signed(in_a) < $signed(in_b));
      OP_LTU:  short_res = W'(in_a < in_b);
      default: short_res = '0;
    endcase
  end

  // acc holds {hi, lo}: product halves for MUL, {remainder, quotient}
  // for DIV, so both finish with the result in the same slices.
  always_comb begin
    op_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
    op_lo   = (op_q == OP_MUL) || (op_q == OP_DIVU);
    mul_sum = {1'b0, acc_q[2*W-1:W]} +
              (acc_q[0] ? {1'b0, b_q} : '0);
    mul_acc = {mul_sum, acc_q[W-1:1]};
    rem_sh  = acc_q[2*W-1:W-1];
    div_try = rem_sh - {1'b0, b_q};
    if (div_try[W]) begin
      div_acc = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      div_acc = {div_try[W-1:0], acc_q[W-2:0], 1'b1};
    end
    step_acc = op_div ? div_acc : mul_acc;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cf_d    = cf_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (in_long) begin
            state_d = S_BUSY;
            op_d    = in_op;
            b_d     = in_b;
            cnt_d   = CNT_INIT;
            acc_d   = {{W{1'b0}}, in_a};
            cf_d    = 1'b0;
            dz_d    = 1'b0;
          end else begin
            state_d = S_DONE;
            res_d   = short_res;
            cf_d    = short_cf;
            dz_d    = 1'b0;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (op_div && b_q == '0) begin
          state_d = S_DONE;
          res_d   = (op_q == OP_DIVU) ? {W{1'b1}} : acc_q[W-1:0];
          dz_d    = 1'b1;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res_d   = op_lo ? step_acc[W-1:0] : step_acc[2*W-1:W];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cf_q    <= cf_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mbscore_alu_mc.sv
// Directed bench for mbscore_alu_mc: latency, results, flags,
// back-to-back issue, backpressure and mid-op reset.
module tb_mbscore_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_cf;
  logic        out_dz;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] ADD = 5'd0, ADDU = 5'd1, SUB = 5'd2;
  localparam logic [4:0] SUBU = 5'd3, AND_ = 5'd4, OR_ = 5'd5;
  localparam logic [4:0] XOR_ = 5'd6, NOR_ = 5'd7, SLL = 5'd8;
  localparam logic [4:0] SRL = 5'd9, SRA = 5'd10, EQ = 5'd11;
  localparam logic [4:0] NE = 5'd12, LT = 5'd13, LTU = 5'd14;
  localparam logic [4:0] MUL = 5'd15, MULHU = 5'd16;
  localparam logic [4:0] DIVU = 5'd17, REMU = 5'd18;

  always #5 clk = ~clk;

  mbscore_alu_mc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cf(out_cf), .out_dz(out_dz)
  );

  task automatic send(input logic [4:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 ||
        out_cf !== 1'b0 || out_dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: v=%b d=%h cf=%b dz=%b want 0",
               out_valid, out_data, out_cf, out_dz);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    int cyc;
    send(ADD, 32'hFFFF_FFFF, 32'h1);
    wait_valid(cyc);
    checks++;
    if (cyc !== 1 || out_data !== 32'h0 || out_cf !== 1'b1 ||
        out_dz !== 1'b0) begin
      errors++;
      $display("FAIL add: lat=%0d d=%h cf=%b want 1 0 1",
               cyc, out_data, out_cf);
    end
    consume();
    send(SUB, 32'd3, 32'd5);
    wait_valid(cyc);
    checks++;
    if (cyc !== 1 || out_data !== 32'hFFFF_FFFE || out_cf !== 1'b1) begin
      errors++;
      $display("FAIL sub: lat=%0d d=%h cf=%b want 1 fffffffe 1",
               cyc, out_data, out_cf);
    end
    consume();
    send(ADDU, 32'hFFFF_FFFF, 32'h1);
    wait_valid(cyc);
    checks++;
    if (out_data !== 32'h0 || out_cf !== 1'b0) begin
      errors++;
      $display("FAIL addu: d=%h cf=%b want 0 0", out_data, out_cf);
    end
    consume();
  endtask

  task automatic test_mul();
    int cyc;
    send(MUL, 32'h0001_0003, 32'h0002_0005);
    in_valid = 1'b1;
    in_op = ADD;
    in_a = 32'h0;
    in_b = 32'h0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: got %b want 0", in_ready);
    end
    wait_valid(cyc);
    in_valid = 1'b0;
    checks++;
    if (cyc !== 33 || out_data !== 32'h000B_000F || out_cf !== 1'b0) begin
      errors++;
      $display("FAIL mul: lat=%0d d=%h want 33 000b000f", cyc, out_data);
    end
    consume();
    send(MULHU, 32'h0001_0003, 32'h0002_0005);
    wait_valid(cyc);
    checks++;
    if (cyc !== 33 || out_data !== 32'h0000_0002) begin
      errors++;
      $display("FAIL mulhu: lat=%0d d=%h want 33 2", cyc, out_data);
    end
    consume();
    send(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(cyc);
    checks++;
    if (out_data !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mulhu_max: d=%h want fffffffe", out_data);
    end
    consume();
  endtask

  task automatic test_div();
    int cyc;
    send(DIVU, 32'd100, 32'd7);
    wait_valid(cyc);
    checks++;
    if (cyc !== 33 || out_data !== 32'd14 || out_dz !== 1'b0) begin
      errors++;
      $display("FAIL divu: lat=%0d d=%h dz=%b want 33 e 0",
               cyc, out_data, out_dz);
    end
    consume();
    send(REMU, 32'd100, 32'd7);
    wait_valid(cyc);
    checks++;
    if (out_data !== 32'd2 || out_dz !== 1'b0) begin
      errors++;
      $display("FAIL remu: d=%h dz=%b want 2 0", out_data, out_dz);
    end
    consume();
    send(DIVU, 32'd5, 32'd0);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2 || out_data !== 32'hFFFF_FFFF || out_dz !== 1'b1) begin
      errors++;
      $display("FAIL divu_z: lat=%0d d=%h dz=%b want 2 ffffffff 1",
               cyc, out_data, out_dz);
    end
    consume();
    send(REMU, 32'd5, 32'd0);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2 || out_data !== 32'd5 || out_dz !== 1'b1) begin
      errors++;
      $display("FAIL remu_z: lat=%0d d=%h dz=%b want 2 5 1",
               cyc, out_data, out_dz);
    end
    consume();
  endtask

  task automatic test_misc();
    logic [4:0]  ops [9] = '{SUBU, NOR_, SLL, SRL, EQ, NE, LT, LTU, 5'd25};
    logic [31:0] av [9] = '{32'd3, 32'h0, 32'h1, 32'h8000_0000, 32'd5,
                            32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] bv [9] = '{32'd5, 32'hF, 32'h21, 32'd31, 32'd5,
                            32'd5, 32'd1, 32'd1, 32'd8};
    logic [31:0] ev [9] = '{32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'h2, 32'h1,
                            32'h1, 32'h0, 32'h1, 32'h0, 32'h0};
    int cyc;
    for (int i = 0; i < 9; i++) begin
      send(ops[i], av[i], bv[i]);
      wait_valid(cyc);
      checks++;
      if (cyc !== 1 || out_data !== ev[i] || out_cf !== 1'b0) begin
        errors++;
        $display("FAIL misc%0d: lat=%0d d=%h cf=%b want 1 %h 0",
                 i, cyc, out_data, out_cf, ev[i]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = AND_;
    in_a = 32'hF0F0_00FF;
    in_b = 32'h0FF0_0F0F;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00F0_000F ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_and: v=%b d=%h rdy=%b want 1 00f0000f 1",
               out_valid, out_data, in_ready);
    end
    in_op = OR_;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFF0_0FFF) begin
      errors++;
      $display("FAIL b2b_or: v=%b d=%h want 1 fff00fff",
               out_valid, out_data);
    end
    in_op = SRA;
    in_a = 32'h8000_0000;
    in_b = 32'd4;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hF800_0000) begin
      errors++;
      $display("FAIL b2b_sra: v=%b d=%h want 1 f8000000",
               out_valid, out_data);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    send(XOR_, 32'hAAAA_5555, 32'hFFFF_0000);
    in_valid = 1'b1;
    in_op = ADD;
    in_a = 32'd1;
    in_b = 32'd1;
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h5555_5555 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp%0d: v=%b d=%h rdy=%b want 1 55555555 0",
                 i, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen = 0;
    send(DIVU, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: v=%b d=%h rdy=%b want 0 0 1",
               out_valid, out_data, in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_ghost: valid cycles=%0d want 0", seen);
    end
    send(ADD, 32'd2, 32'd2);
    wait_valid(cyc);
    checks++;
    if (cyc !== 1 || out_data !== 32'd4 || out_cf !== 1'b0) begin
      errors++;
      $display("FAIL rst_add: lat=%0d d=%h cf=%b want 1 4 0",
               cyc, out_data, out_cf);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_misc();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
